seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit seven-segment display. It shares a single hex-to-seven-segment decoder across `NDIG` digits: it presents one digit's nibble to the decoder per scan slot, registers the returned segment pattern, and drives the shared segment bus plus a one-hot, active-low digit select. New display contents arrive through a valid/ready write port. They are double-buffered and applied only at frame boundaries, so a frame never tears. Each slot begins with a blanking window to suppress ghosting.

## Interface
Parameters:
- `NDIG`, 8: number of digits, ≥2.
- `DIV`, 1000: clock cycles per digit slot.
- `BLANK`, 16: blanking cycles at the start of each slot; 1 ≤ `BLANK` < `DIV`.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `wr_valid` input 1: new display contents offered.
- `wr_ready` output 1: pending buffer empty; a write is accepted on `wr_valid & wr_ready`.
- `wr_data` input 4*NDIG: nibble i is digit i, where digit 0 is least significant.
- `wr_en` input NDIG: per-digit enable; 0 keeps that digit dark.
- `wr_dp` input NDIG: per-digit decimal point; 1 means lit.
- `wr_lz` input 1: leading-zero suppression enable.
- `dec_hex` output 4: nibble presented to the shared decoder.
- `dec_seg` input 7: decoder result, active-low, purely combinational from `dec_hex`.
- `seg` output 7: segment bus, active-low.
- `dp` output 1: decimal point, active-low.
- `an` output NDIG: digit select, active-low, at most one bit low.
- `frame_tick` output 1: one-cycle pulse marking the start of a frame.

## Operation
- State: slot counter `cnt` (0..DIV-1), digit index `idx` (0..NDIG-1), front buffer (data/en/dp/lz), pending buffer plus `pend_full` flag.
- Per-slot phases, set by `cnt`:
  - BLANK: `cnt` < `BLANK`.
  - SHOW: `cnt` ≥ `BLANK`.
- Slot advance:
  - `cnt` increments every cycle.
  - When `cnt` = DIV-1: `cnt` goes to 0 and `idx` goes to `idx`+1.
  - `idx` wraps from NDIG-1 to 0.
- Frame boundary: the cycle with `cnt` = DIV-1 and `idx` = NDIG-1.
- Write port: on accept, load the pending buffer and set `pend_full`. `wr_ready` = `!pend_full` (registered).
- Swap: at a frame boundary with `pend_full` = 1, copy pending to front and clear `pend_full`. `wr_ready` rises the next cycle.
- Write accepted in the boundary cycle (`pend_full` was 0): it lands in the pending buffer and is swapped at the *next* boundary. This cycle's swap test uses the pre-cycle `pend_full` value.
- `dec_hex` = front nibble[`idx`], combinational from registers.
- Digit i is suppressed when front `lz` = 1, i ≠ 0, and nibbles NDIG-1 down to i are all 0. Digit 0 is never suppressed.
- Next-output computation, registered into `seg`/`dp`/`an`:
  - BLANK phase, or digit disabled, or digit suppressed: `an` = all 1, `seg` = 7'h7F, `dp` = 1.
  - Otherwise: `an` = ~(1<<`idx`), `seg` = `dec_seg`, `dp` = ~front `dp`[`idx`].

## Timing
- Reset (asynchronous, immediate):
  - counters: `cnt` = 0, `idx` = 0.
  - buffers: front data/en/dp/lz = 0; `pend_full` = 0.
  - outputs: `an` = all 1, `seg` = 7'h7F, `dp` = 1, `frame_tick` = 0, `wr_ready` = 1, `dec_hex` = 0.
  - After reset the display is dark, because all enables are 0.
- Reset mid-slot or mid-frame: all state and outputs take their reset values immediately; scanning restarts at `idx` 0, `cnt` 0 after release. A held pending write is discarded.
- Output latency:
  - `seg`/`an`/`dp` lag (`idx`,`cnt`) by exactly one cycle.
  - Each slot drives BLANK blank cycles, then DIV-BLANK lit cycles.
  - The display is dark for slot cycles 0..BLANK-1 of the delayed sequence, i.e. clock cycles 1..BLANK after a slot starts.
- Front-buffer changes take effect on the first cycle of `idx` 0 after the swap.
- `frame_tick` is high in the cycle after each frame boundary, i.e. the first cycle of `idx` 0. It pulses every NDIG·DIV cycles whether or not a swap happened. There is no tick after reset until the first boundary.
- Write latency: accept to first lit pixel of new data ≤ 2·NDIG·DIV + BLANK + 1 cycles.

## Test plan
All scenarios use `NDIG`=4, `DIV`=8, `BLANK`=2.
- Reset: hold `rst_n`=0, then release.
  - Before the first write: `an`=4'hF, `seg`=7'h7F, `dp`=1, `wr_ready`=1.
  - First `frame_tick` at cycle 32 after release.
- Basic display: write `wr_data`=16'h1234, `wr_en`=4'hF, `wr_dp`=4'b0100, `wr_lz`=0.
  - After the next `frame_tick`, the digit-2 slot shows `an`=4'b1011, `seg`=7'b0010010, `dp`=0 for 6 cycles, preceded by 2 dark cycles.
  - The digit-0 slot shows `seg`=7'b1001100.
- Leading-zero suppression:
  - Data 16'h0050, `wr_lz`=1: digits 3 and 2 dark; digit 1 shows 7'b0100100; digit 0 shows 7'b0000001.
  - Data 16'h0000: only digit 0 is lit.
- Enable mask: `wr_en`=4'b0101 with data 16'h8888. The digit-1 and digit-3 slots keep `an`=4'hF throughout; digits 0 and 2 show 7'b0000000.
- Backpressure and no tearing:
  - Write A mid-frame; `wr_ready` drops.
  - Hold write B valid: it is not accepted until the cycle after the boundary.
  - A is displayed for one full frame, then B for all 4 digits. No frame mixes A and B digits.
- Reset mid-operation: assert `rst_n`=0 at `idx`=2, `cnt`=5 with `pend_full`=1.
  - Same cycle: `an`=4'hF, `wr_ready`=1.
  - After release: display dark until a new write and swap.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for a multi-digit
//                seven-segment display. One external hex decoder is shared
//                across all NDIG digits: the current digit's nibble is
//                presented on dec_hex, the decoder result (dec_seg) is
//                registered onto the segment bus, and a one-hot active-low
//                digit select is driven alongside it. New display contents
//                arrive on a valid/ready port into a pending buffer and are
//                copied to the front buffer only at frame boundaries, so a
//                frame never mixes old and new contents. Every slot starts
//                with a blanking window to suppress ghosting.
//
//  Parameters  : NDIG  - number of digits (>= 2)
//                DIV   - clock cycles per digit slot
//                BLANK - dark cycles at the start of each slot (1..DIV-1)
//
//  Ports       : clk        - clock, all state on the rising edge
//                rst_n      - asynchronous active-low reset
//                wr_valid   - new display contents offered
//                wr_ready   - pending buffer empty (write accepted on
//                             wr_valid & wr_ready)
//                wr_data    - 4*NDIG bits, nibble i is digit i (0 = LSD)
//                wr_en      - per-digit enable, 0 keeps the digit dark
//                wr_dp      - per-digit decimal point, 1 = lit
//                wr_lz      - leading-zero suppression enable
//                dec_hex    - nibble presented to the shared decoder
//                dec_seg    - decoder result (active-low, combinational)
//                seg        - segment bus, active-low
//                dp         - decimal point, active-low
//                an         - digit select, active-low, at most one low
//                frame_tick - one-cycle pulse on the first cycle of a frame
//
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]   wr_en,
  input  logic [NDIG-1:0]   wr_dp,
  input  logic              wr_lz,
  output logic [3:0]        dec_hex,
  input  logic [6:0]        dec_seg,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_tick
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_iw = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DIV - 1);
  localparam logic [c_cw-1:0] c_blank    = c_cw'(BLANK);
  localparam logic [c_iw-1:0] c_idx_last = c_iw'(NDIG - 1);
  localparam logic [6:0]      c_seg_off  = 7'h7F;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Scan position
  logic [c_cw-1:0]   r_cnt;
  logic [c_iw-1:0]   r_idx;

  // Front buffer: what is being scanned out right now
  logic [4*NDIG-1:0] r_front_data;
  logic [NDIG-1:0]   r_front_en;
  logic [NDIG-1:0]   r_front_dp;
  logic              r_front_lz;

  // Pending buffer: last accepted write, waiting for a frame boundary
  logic [4*NDIG-1:0] r_pend_data;
  logic [NDIG-1:0]   r_pend_en;
  logic [NDIG-1:0]   r_pend_dp;
  logic              r_pend_lz;
  logic              r_pend_full;

  // Registered display outputs
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [NDIG-1:0]   r_an;
  logic              r_frame_tick;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_cnt_last;
  logic              w_idx_last;
  logic              w_boundary;
  logic              w_accept;
  logic              w_swap;
  logic              w_blank;

  assign w_cnt_last = (r_cnt == c_cnt_last);
  assign w_idx_last = (r_idx == c_idx_last);
  assign w_boundary = w_cnt_last & w_idx_last;
  // Both the accept and the swap look at r_pend_full as it stood before this
  // edge, so a write landing in the boundary cycle waits for the next frame.
  assign w_accept   = wr_valid & ~r_pend_full;
  assign w_swap     = w_boundary & r_pend_full;
  assign w_blank    = (r_cnt < c_blank);

  // --------------------------------------------------------------------------
  // Current-digit selection and leading-zero suppression
  // --------------------------------------------------------------------------
  // Walking from the most significant digit downwards, w_upper_zero stays
  // high while every nibble seen so far (this one included) is zero. A digit
  // is suppressed while that run holds; digit 0 always survives so a value of
  // zero still shows a single "0".
  logic [3:0]        w_hex;
  logic              w_cur_en;
  logic              w_cur_dp;
  logic              w_cur_sup;
  logic              w_upper_zero;
  logic [NDIG-1:0]   w_sup;
  logic [NDIG-1:0]   w_an_sel;

  always_comb begin
    w_hex        = 4'h0;
    w_cur_en     = 1'b0;
    w_cur_dp     = 1'b0;
    w_cur_sup    = 1'b0;
    w_upper_zero = 1'b1;
    w_sup        = '0;
    w_an_sel     = '1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero & (r_front_data[4*i +: 4] == 4'h0);
      if (i != 0) begin
        w_sup[i] = r_front_lz & w_upper_zero;
      end
      if (r_idx == c_iw'(i)) begin
        w_hex       = r_front_data[4*i +: 4];
        w_cur_en    = r_front_en[i];
        w_cur_dp    = r_front_dp[i];
        w_cur_sup   = w_sup[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  logic w_lit;
  assign w_lit = ~w_blank & w_cur_en & ~w_cur_sup;

  // --------------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending buffer and write handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data <= '0;
      r_pend_en   <= '0;
      r_pend_dp   <= '0;
      r_pend_lz   <= 1'b0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_data <= wr_data;
        r_pend_en   <= wr_en;
        r_pend_dp   <= wr_dp;
        r_pend_lz   <= wr_lz;
        r_pend_full <= 1'b1;
      end else if (w_swap) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Front buffer: only ever changes at a frame boundary
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front_data <= '0;
      r_front_en   <= '0;
      r_front_dp   <= '0;
      r_front_lz   <= 1'b0;
    end else if (w_swap) begin
      r_front_data <= r_pend_data;
      r_front_en   <= r_pend_en;
      r_front_dp   <= r_pend_dp;
      r_front_lz   <= r_pend_lz;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: one cycle behind (r_idx, r_cnt)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= c_seg_off;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_lit) begin
        r_an  <= w_an_sel;
        r_seg <= dec_seg;
        r_dp  <= ~w_cur_dp;
      end else begin
        r_an  <= '1;
        r_seg <= c_seg_off;
        r_dp  <= 1'b1;
      end
      // The boundary cycle is the last of a frame, so the registered copy
      // lands exactly on the first cycle of digit 0.
      r_frame_tick <= w_boundary;
    end
  end

  // --------------------------------------------------------------------------
  // Port assignments
  // --------------------------------------------------------------------------
  assign wr_ready   = ~r_pend_full;
  assign dec_hex    = w_hex;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl with NDIG=4, DIV=8,
//                BLANK=2. A frame-level reference model (scan position taken
//                as cycles-since-reset modulo the frame length) predicts the
//                outputs; directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_en = '0;
  logic [3:0]  wr_dp = '0;
  logic        wr_lz = 1'b0;
  logic [3:0]  dec_hex;
  logic [6:0]  dec_seg;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Active-low abcdefg decoder (bit 6 = a, bit 0 = g)
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  assign dec_seg = hex7(dec_hex);

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_dp      (wr_dp),
    .wr_lz      (wr_lz),
    .dec_hex    (dec_hex),
    .dec_seg    (dec_seg),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic        lz;
  } frame_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vis_t;

  frame_t     m_front, m_pend;
  logic       m_pend_full;
  int         m_n;          // edges since reset release = current scan position
  int         last_p;       // scan position consumed by the latest edge
  vis_t       exp_vis;
  logic       exp_tick, exp_ready;
  logic [3:0] exp_hex;

  logic [3:0] cap_an [FRAME];
  logic [6:0] cap_seg[FRAME];
  logic       cap_dp [FRAME];

  // What the display shows for frame contents f at scan position p
  function automatic vis_t show(input frame_t f, input int p);
    int          digit;
    int          c;
    logic [15:0] upper;
    vis_t        v;
    digit = (p / DIV) % NDIG;
    c     = p % DIV;
    upper = f.data >> (4 * digit);
    v.an  = 4'hF;
    v.seg = 7'h7F;
    v.dp  = 1'b1;
    if (c >= BLANK && f.en[digit] && !(f.lz && digit != 0 && upper == 16'h0)) begin
      v.an  = ~(4'b0001 << digit);
      v.seg = hex7(upper[3:0]);
      v.dp  = ~f.dp[digit];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_front     = '0;
    m_pend      = '0;
    m_pend_full = 1'b0;
    m_n         = 0;
  endtask

  // Drive one cycle of inputs, advance the model, step past the edge.
  task automatic tick(input logic v, input frame_t in);
    int   p;
    logic acc;
    logic [15:0] sh;
    wr_valid = v;
    wr_data  = in.data;
    wr_en    = in.en;
    wr_dp    = in.dp;
    wr_lz    = in.lz;
    p        = m_n;
    exp_vis  = show(m_front, p);
    exp_tick = ((p % FRAME) == FRAME - 1);
    acc      = v && !m_pend_full;
    if (exp_tick && m_pend_full) begin
      m_front     = m_pend;
      m_pend_full = 1'b0;
    end
    if (acc) begin
      m_pend      = in;
      m_pend_full = 1'b1;
    end
    last_p    = p;
    m_n       = m_n + 1;
    exp_ready = !m_pend_full;
    sh        = m_front.data >> (4 * ((m_n / DIV) % NDIG));
    exp_hex   = sh[3:0];
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a frame_tick sample, then record the next full frame.
  task automatic capture();
    int guard;
    guard = 0;
    while (frame_tick !== 1'b1 && guard < 2 * FRAME) begin
      tick(1'b0, '0);
      guard++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL capture_wait frame_tick=%b after %0d cycles, required 1", frame_tick, guard);
    end
    for (int j = 0; j < FRAME; j++) begin
      tick(1'b0, '0);
      cap_an[j]  = an;
      cap_seg[j] = seg;
      cap_dp[j]  = dp;
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    int first;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF)      begin errors++; $display("FAIL rst_an got %h exp F", an); end
    checks++; if (seg !== 7'h7F)    begin errors++; $display("FAIL rst_seg got %h exp 7F", seg); end
    checks++; if (dp !== 1'b1)      begin errors++; $display("FAIL rst_dp got %b exp 1", dp); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", frame_tick); end
    checks++; if (dec_hex !== 4'h0) begin errors++; $display("FAIL rst_hex got %h exp 0", dec_hex); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, '0);
      if (frame_tick === 1'b1 && first < 0) first = i;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        errors++;
        $display("FAIL rst_dark cycle %0d an=%h seg=%h dp=%b, required F/7F/1", i, an, seg, dp);
      end
    end
    checks++; if (first != 32) begin errors++; $display("FAIL rst_first_tick at cycle %0d, required 32", first); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_idle got %b exp 1", wr_ready); end
  endtask

  task automatic test_basic();
    frame_t f;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    f = '{data: 16'h1234, en: 4'hF, dp: 4'b0100, lz: 1'b0};
    tick(1'b1, f);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got %b exp 0", wr_ready); end
    tick(1'b0, '0);
    capture();
    for (int j = 0; j < FRAME; j++) begin
      int dg;
      dg = j / DIV;
      if ((j % DIV) < BLANK) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = ~(4'b0001 << dg);
        case (dg)
          0: es = 7'b1001100;
          1: es = 7'b0000110;
          2: es = 7'b0010010;
          default: es = 7'b1001111;
        endcase
        ed = (dg == 2) ? 1'b0 : 1'b1;
      end
      checks++;
      if (cap_an[j] !== ea || cap_seg[j] !== es || cap_dp[j] !== ed) begin
        errors++;
        $display("FAIL basic_pos%0d an/seg/dp got %h/%b/%b exp %h/%b/%b",
                 j, cap_an[j], cap_seg[j], cap_dp[j], ea, es, ed);
      end
    end
  endtask

  task automatic test_lz();
    frame_t     f;
    logic [3:0] litmask;
    logic [6:0] segs[NDIG];
    logic [3:0] ea;
    logic [6:0] es;
    for (int sc = 0; sc < 2; sc++) begin
      if (sc == 0) begin
        f = '{data: 16'h0050, en: 4'hF, dp: 4'h0, lz: 1'b1};
        litmask = 4'b0011;
        segs[0] = 7'b0000001; segs[1] = 7'b0100100;
      end else begin
        f = '{data: 16'h0000, en: 4'hF, dp: 4'h0, lz: 1'b1};
        litmask = 4'b0001;
        segs[0] = 7'b0000001; segs[1] = 7'h7F;
      end
      segs[2] = 7'h7F; segs[3] = 7'h7F;
      tick(1'b1, f);
      tick(1'b0, '0);
      capture();
      for (int j = 0; j < FRAME; j++) begin
        int dg;
        dg = j / DIV;
        if ((j % DIV) >= BLANK && litmask[dg]) begin
          ea = ~(4'b0001 << dg); es = segs[dg];
        end else begin
          ea = 4'hF; es = 7'h7F;
        end
        checks++;
        if (cap_an[j] !== ea || cap_seg[j] !== es) begin
          errors++;
          $display("FAIL lz%0d_pos%0d an/seg got %h/%b exp %h/%b", sc, j, cap_an[j], cap_seg[j], ea, es);
        end
      end
    end
  endtask

  task automatic test_enable();
    frame_t     f;
    logic [3:0] ea;
    logic [6:0] es;
    f = '{data: 16'h8888, en: 4'b0101, dp: 4'h0, lz: 1'b0};
    tick(1'b1, f);
    tick(1'b0, '0);
    capture();
    for (int j = 0; j < FRAME; j++) begin
      int dg;
      dg = j / DIV;
      if ((j % DIV) >= BLANK && (dg == 0 || dg == 2)) begin
        ea = ~(4'b0001 << dg); es = 7'b0000000;
      end else begin
        ea = 4'hF; es = 7'h7F;
      end
      checks++;
      if (cap_an[j] !== ea || cap_seg[j] !== es) begin
        errors++;
        $display("FAIL en_pos%0d an/seg got %h/%b exp %h/%b", j, cap_an[j], cap_seg[j], ea, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t     fa, fb;
    logic       rb;
    int         acc_p;
    int         guard;
    logic [15:0] sh;
    logic [6:0] es;
    logic [3:0] ea;
    fa = '{data: 16'h1357, en: 4'hF, dp: 4'h0, lz: 1'b0};
    fb = '{data: 16'h2468, en: 4'hF, dp: 4'hF, lz: 1'b0};
    guard = 0;
    while ((m_n % FRAME) != 10 && guard < FRAME) begin
      tick(1'b0, '0);
      guard++;
    end
    tick(1'b1, fa);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b exp 0", wr_ready); end
    acc_p = -1;
    for (int g = 0; g < 2 * FRAME; g++) begin
      rb = wr_ready;
      tick(1'b1, fb);
      if (rb === 1'b1) begin
        acc_p = last_p;
        break;
      end
    end
    checks++;
    if (acc_p < 0 || (acc_p % FRAME) != 0) begin
      errors++;
      $display("FAIL bp_accept_pos got %0d exp frame position 0", (acc_p < 0) ? -1 : acc_p % FRAME);
    end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got %b exp 0", wr_ready); end
    // Remainder of frame A (sample k shows scan position k)
    for (int k = 1; k < FRAME; k++) begin
      int dg;
      tick(1'b0, '0);
      dg = k / DIV;
      sh = fa.data >> (4 * dg);
      if ((k % DIV) >= BLANK) begin
        ea = ~(4'b0001 << dg); es = hex7(sh[3:0]);
      end else begin
        ea = 4'hF; es = 7'h7F;
      end
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL bp_frameA_pos%0d an/seg got %h/%b exp %h/%b", k, an, seg, ea, es);
      end
    end
    capture();
    for (int j = 0; j < FRAME; j++) begin
      int dg;
      dg = j / DIV;
      sh = fb.data >> (4 * dg);
      if ((j % DIV) >= BLANK) begin
        ea = ~(4'b0001 << dg); es = hex7(sh[3:0]);
      end else begin
        ea = 4'hF; es = 7'h7F;
      end
      checks++;
      if (cap_an[j] !== ea || cap_seg[j] !== es || cap_dp[j] !== ((j % DIV) < BLANK)) begin
        errors++;
        $display("FAIL bp_frameB_pos%0d an/seg/dp got %h/%b/%b exp %h/%b/%b",
                 j, cap_an[j], cap_seg[j], cap_dp[j], ea, es, (j % DIV) < BLANK);
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    int     guard;
    int     first;
    f = '{data: 16'h9999, en: 4'hF, dp: 4'hF, lz: 1'b0};
    guard = 0;
    while ((m_n % FRAME) != 12 && guard < FRAME) begin
      tick(1'b0, '0);
      guard++;
    end
    tick(1'b1, f);
    guard = 0;
    while ((m_n % FRAME) != 21 && guard < FRAME) begin
      tick(1'b0, '0);
      guard++;
    end
    // Scan state is now idx 2, cnt 5 with a write held in the pending buffer
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_ready got %b exp 0", wr_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF)        begin errors++; $display("FAIL mid_an got %h exp F", an); end
    checks++; if (wr_ready !== 1'b1)  begin errors++; $display("FAIL mid_ready got %b exp 1", wr_ready); end
    checks++; if (seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL mid_seg_dp got %h/%b exp 7F/1", seg, dp); end
    checks++; if (dec_hex !== 4'h0)   begin errors++; $display("FAIL mid_hex got %h exp 0", dec_hex); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    first = -1;
    for (int i = 1; i <= 2 * FRAME + 4; i++) begin
      tick(1'b0, '0);
      if (frame_tick === 1'b1 && first < 0) first = i;
      checks++;
      if (an !== 4'hF || wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_dark cycle %0d an=%h ready=%b, required F/1", i, an, wr_ready);
      end
    end
    checks++; if (first != 32) begin errors++; $display("FAIL mid_first_tick at cycle %0d, required 32", first); end
  endtask

  task automatic test_random();
    frame_t f;
    logic   v;
    for (int k = 0; k < 6 * FRAME; k++) begin
      f.data = 16'($urandom) >> (4 * $urandom_range(0, 3));
      f.en   = 4'($urandom);
      f.dp   = 4'($urandom);
      f.lz   = 1'($urandom);
      v      = ($urandom_range(0, 11) == 0);
      tick(v, f);
      checks++; if (an !== exp_vis.an)   begin errors++; $display("FAIL rnd_an t=%0d got %h exp %h", k, an, exp_vis.an); end
      checks++; if (seg !== exp_vis.seg) begin errors++; $display("FAIL rnd_seg t=%0d got %b exp %b", k, seg, exp_vis.seg); end
      checks++; if (dp !== exp_vis.dp)   begin errors++; $display("FAIL rnd_dp t=%0d got %b exp %b", k, dp, exp_vis.dp); end
      checks++; if (frame_tick !== exp_tick) begin errors++; $display("FAIL rnd_tick t=%0d got %b exp %b", k, frame_tick, exp_tick); end
      checks++; if (wr_ready !== exp_ready)  begin errors++; $display("FAIL rnd_ready t=%0d got %b exp %b", k, wr_ready, exp_ready); end
      checks++; if (dec_hex !== exp_hex)     begin errors++; $display("FAIL rnd_hex t=%0d got %h exp %h", k, dec_hex, exp_hex); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_lz();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
